// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: inverse S-box, GF(2^8) multipliers,
// round count helper and the iterative controller's state encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        return gf_mul2(gf_mul2(gf_mul2(x))) ^ x;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] x);
        return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(x) ^ x;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] x);
        return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(gf_mul2(x)) ^ x;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] x);
        return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(gf_mul2(x)) ^ gf_mul2(x);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES decryption round: InvShiftRows, InvSubBytes,
// AddRoundKey and (unless last) InvMixColumns. Byte 0 sits in bits [127:120].
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [7:0] ark [16];
    logic [7:0] mix [16];

    always_comb begin
        state_out = '0;
        // Byte (row r, column c) comes from column (c - r) mod 4 of the input.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[r + 4*c] = INV_SBOX[state_in[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]]
                             ^ round_key[127 - 8*(r + 4*c) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix[4*c+0] = gf_mul14(ark[4*c]) ^ gf_mul11(ark[4*c+1]) ^ gf_mul13(ark[4*c+2]) ^ gf_mul9(ark[4*c+3]);
            mix[4*c+1] = gf_mul9(ark[4*c])  ^ gf_mul14(ark[4*c+1]) ^ gf_mul11(ark[4*c+2]) ^ gf_mul13(ark[4*c+3]);
            mix[4*c+2] = gf_mul13(ark[4*c]) ^ gf_mul9(ark[4*c+1])  ^ gf_mul14(ark[4*c+2]) ^ gf_mul11(ark[4*c+3]);
            mix[4*c+3] = gf_mul11(ark[4*c]) ^ gf_mul13(ark[4*c+1]) ^ gf_mul9(ark[4*c+2])  ^ gf_mul14(ark[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            state_out[127 - 8*i -: 8] = last ? ark[i] : mix[i];
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock over a latched,
// pre-expanded key schedule, with valid/ready on both sides.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter  int Nk = 4,
    localparam int Nr = nr_of(Nk)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [127:0]             encryptedText,
    input  logic [128*(Nr+1)-1:0]    keys,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [127:0]             decryptedText,
    output logic                     busy
);

    localparam int RW = $clog2(Nr);
    localparam logic [RW-1:0] RND_INIT = RW'(Nr - 1);

    aes_state_e            st_q, st_d;
    logic                  accept;
    logic                  last;
    logic [RW-1:0]         rnd_q;
    logic [127:0]          state_q;
    logic [127:0]          round_out;
    logic [128*(Nr+1)-1:0] key_q;
    logic [127:0]          rk [Nr+1];

    for (genvar r = 0; r <= Nr; r++) begin : g_rk
        assign rk[r] = key_q[128*r +: 128];
    end

    assign last      = (rnd_q == '0);
    assign out_valid = (st_q == ST_DONE);
    assign busy      = (st_q == ST_ROUND);

    aes_inv_round u_round (
        .state_in  (state_q),
        .round_key (rk[rnd_q]),
        .last      (last),
        .state_out (round_out)
    );

    always_comb begin
        st_d     = st_q;
        in_ready = 1'b0;
        case (st_q)
            ST_IDLE:  in_ready = 1'b1;
            ST_ROUND: if (last) st_d = ST_DONE;
            ST_DONE:  begin
                in_ready = out_ready;
                if (out_ready) st_d = ST_IDLE;
            end
            default:  st_d = ST_IDLE;
        endcase
        accept = in_valid && in_ready;
        if (accept) st_d = ST_ROUND;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q          <= ST_IDLE;
            rnd_q         <= '0;
            state_q       <= '0;
            decryptedText <= '0;
        end else begin
            st_q <= st_d;
            if (accept) begin
                // Initial AddRoundKey uses the incoming schedule, not the stale latched one.
                state_q <= encryptedText ^ keys[128*Nr +: 128];
                rnd_q   <= RND_INIT;
            end else if (st_q == ST_ROUND) begin
                state_q <= round_out;
                if (last) decryptedText <= round_out;
                else      rnd_q         <= rnd_q - RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) key_q <= keys;
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter at Nk=4/6/8 using FIPS-197 vectors;
// key schedules are expanded here with an S-box derived from GF(2^8) inversion.
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic iv4, rdy4, ov4, or4, bz4;  logic [127:0] ct4, pt4;  logic [1407:0] k4;
    logic iv6, rdy6, ov6, or6, bz6;  logic [127:0] ct6, pt6;  logic [1663:0] k6;
    logic iv8, rdy8, ov8, or8, bz8;  logic [127:0] ct8, pt8;  logic [1919:0] k8;

    aes_inv_cipher_iter #(.Nk(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4),
        .encryptedText(ct4), .keys(k4), .out_valid(ov4), .out_ready(or4), .decryptedText(pt4), .busy(bz4));
    aes_inv_cipher_iter #(.Nk(6)) u6 (.clk(clk), .rst(rst), .in_valid(iv6), .in_ready(rdy6),
        .encryptedText(ct6), .keys(k6), .out_valid(ov6), .out_ready(or6), .decryptedText(pt6), .busy(bz6));
    aes_inv_cipher_iter #(.Nk(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
        .encryptedText(ct8), .keys(k8), .out_valid(ov8), .out_ready(or8), .decryptedText(pt8), .busy(bz8));

    int sel;
    logic ov_s, rdy_s, bz_s;
    logic [127:0] pt_s;
    always_comb begin
        ov_s = ov4; rdy_s = rdy4; bz_s = bz4; pt_s = pt4;
        if (sel == 6) begin ov_s = ov6; rdy_s = rdy6; bz_s = bz6; pt_s = pt6; end
        if (sel == 8) begin ov_s = ov8; rdy_s = rdy8; bz_s = bz8; pt_s = pt8; end
    end

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        logic [1919:0] res = '0;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept_job(input int s);
        @(negedge clk);
        sel = s;
        if (s == 4) iv4 = 1'b1;
        if (s == 6) iv6 = 1'b1;
        if (s == 8) iv8 = 1'b1;
        #1 chk("in_ready_before_accept", 128'(rdy_s), 128'd1);
        @(posedge clk);
        #1;
        iv4 = 1'b0; iv6 = 1'b0; iv8 = 1'b0;
        chk("busy_after_accept", 128'(bz_s), 128'd1);
    endtask

    task automatic wait_out(input int exp_n, input logic [127:0] exp_pt);
        int n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (ov_s) break;
        end
        chk("latency_edges", 128'(n), 128'(exp_n));
        chk("plaintext", pt_s, exp_pt);
    endtask

    logic [1919:0] ks;

    initial begin
        rst = 1'b1; sel = 4;
        iv4 = 1'b0; iv6 = 1'b0; iv8 = 1'b0;
        or4 = 1'b1; or6 = 1'b1; or8 = 1'b1;
        ct4 = CT_C1; ct6 = CT_C2; ct8 = CT_C3;
        ks = expand(4, KEY_C1); k4 = ks[1407:0];
        ks = expand(6, KEY_C2); k6 = ks[1663:0];
        ks = expand(8, KEY_C3); k8 = ks;
        #2;
        chk("reset_out_valid", 128'(ov4), 128'd0);
        chk("reset_busy", 128'(bz4), 128'd0);
        chk("reset_pt4", pt4, 128'd0);
        chk("reset_in_ready", 128'(rdy4), 128'd1);
        chk("reset_pt8", pt8, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        accept_job(4); wait_out(10, PT_C);
        accept_job(6); wait_out(12, PT_C);
        accept_job(8); wait_out(14, PT_C);

        // Backpressure, then back-to-back accept from DONE.
        or4 = 1'b0;
        accept_job(4); wait_out(10, PT_C);
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 128'(ov4), 128'd1);
            chk("hold_pt", pt4, PT_C);
            chk("hold_in_ready", 128'(rdy4), 128'd0);
        end
        @(negedge clk);
        ct4 = CT_B; ks = expand(4, KEY_B); k4 = ks[1407:0];
        iv4 = 1'b1; or4 = 1'b1;
        #1 chk("b2b_in_ready", 128'(rdy4), 128'd1);
        @(posedge clk); #1;
        iv4 = 1'b0;
        chk("b2b_out_valid_fall", 128'(ov4), 128'd0);
        chk("b2b_busy", 128'(bz4), 128'd1);
        wait_out(10, PT_B);
        @(posedge clk); #1;
        chk("idle_out_valid", 128'(ov4), 128'd0);
        chk("idle_in_ready", 128'(rdy4), 128'd1);

        // Inputs scrambled after the accept edge must not matter.
        @(negedge clk);
        ct4 = CT_C1; ks = expand(4, KEY_C1); k4 = ks[1407:0];
        accept_job(4);
        ct4 = '1; k4 = '1;
        wait_out(10, PT_C);
        @(negedge clk);
        ct4 = CT_C1; ks = expand(4, KEY_C1); k4 = ks[1407:0];

        // Asynchronous reset in the middle of a job.
        accept_job(4);
        repeat (4) @(posedge clk);
        #1 chk("busy_before_reset", 128'(bz4), 128'd1);
        #3 rst = 1'b1;
        #1;
        chk("abort_out_valid", 128'(ov4), 128'd0);
        chk("abort_busy", 128'(bz4), 128'd0);
        chk("abort_pt", pt4, 128'd0);
        chk("abort_in_ready", 128'(rdy4), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_reset_in_ready", 128'(rdy4), 128'd1);
        accept_job(4); wait_out(10, PT_C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative, parametrised AES inverse cipher (FIPS-197 InvCipher) for AES-128, AES-192 and AES-256, selected by Nk.
- Performs one decryption round per clock, with a valid/ready handshake on both input and output.
- Consumes a pre-expanded key schedule from the key-expansion block and produces 128-bit plaintext.
- Replaces the combinational inverse-cipher datapath in the decrypt path.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
- Nr, Nk+6, number of rounds; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ciphertext and keys are valid.
- in_ready  output  1  block can accept a new job.
- encryptedText  input  128  ciphertext; byte 0 in bits [127:120].
- keys  input  128*(Nr+1)  expanded schedule; round key r in keys[128*r +: 128].
- out_valid  output  1  decryptedText is valid.
- out_ready  input  1  downstream accepts the result.
- decryptedText  output  128  plaintext.
- busy  output  1  high while rounds are in progress.

Behaviour:
- Reset is asynchronous and active-high. While rst is asserted:
  - state returns to IDLE;
  - out_valid=0, busy=0, decryptedText=0;
  - round counter=0, state register=0.
- in_ready is combinational: 1 in IDLE, or in DONE when out_ready=1.
- The FSM has three states: IDLE, ROUND, DONE.
- Accept occurs on a clock edge where in_valid && in_ready.
  - Latch keys into the internal key register.
  - Load state register = encryptedText ^ roundkey[Nr].
  - Set rnd = Nr-1 and go to ROUND.
- ROUND (busy=1), each cycle:
  - Apply InvShiftRows, then InvSubBytes, then AddRoundKey(roundkey[rnd]).
  - If rnd != 0, also apply InvMixColumns, then decrement rnd.
  - If rnd == 0, skip InvMixColumns, register the result into decryptedText, and go to DONE.
- DONE (out_valid=1): decryptedText is held stable until out_ready=1.
  - On out_ready with no new accept: go to IDLE, out_valid=0.
  - On out_ready with simultaneous in_valid: accept the new job in the same edge and go to ROUND. out_valid falls on that edge.
- Latency:
  - out_valid rises exactly Nr clock edges after the accept edge (10, 12 or 14).
  - Back-to-back throughput is one block per Nr+1 cycles.
- Input signals are ignored outside accept edges.
  - Changing keys or encryptedText mid-job has no effect, because both are latched.
- in_valid while busy: in_ready=0, so nothing is accepted and nothing is lost. The upstream block must hold its data.
- out_ready while out_valid=0 is ignored.
- Reset asserted mid-ROUND aborts the job with no output. After release the block is in IDLE with in_ready=1.
- The rnd counter width is clog2(Nr). It never wraps, because the terminal test is rnd==0 before the decrement.
- The key register is (Nr+1)*128 bits. Round-key selection is a mux on rnd; the unused upper bits for Nk=4/6 do not exist.
- No X is allowed on any output after reset.

Decomposition:
- Package aes_pkg holds:
  - the inverse S-box constant array (256 x 8);
  - gf_mul2/gf_mul9/gf_mul11/gf_mul13/gf_mul14 functions;
  - a function nr_of(Nk);
  - the FSM state enum typedef.
- One combinational sub-module, aes_inv_round. Its interface is:
  - inputs: state_in[127:0], round_key[127:0], last (bypass InvMixColumns);
  - output: state_out[127:0].
- The top-level block instantiates aes_inv_round once and contains only the FSM, counter and registers.

Test Plan:
- Nk=4, FIPS-197 C.1 (key 000102…0f expanded), ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> out_valid after 10 edges with pt 00112233445566778899aabbccddeeff.
- Nk=6, C.2 (key 000102…17) ct dda97ca4864cdfe06eaf70a0ec0d7191 -> pt 00112233…eeff after 12 edges.
- Nk=8, C.3 (key 000102…1f) ct 8ea2b7ca516745bfeafc49904b496089 -> pt 00112233…eeff after 14 edges.
- Backpressure and back-to-back, Nk=4:
  - Hold out_ready=0 for 5 cycles -> out_valid and pt stay stable and in_ready=0.
  - Then assert out_ready together with in_valid carrying a second ct -> the second job is accepted in the same edge and its pt appears 10 edges later.
- Mid-job input changes: change encryptedText/keys to all-ones during ROUND -> the result is still the C.1 plaintext.
- Reset mid-operation: assert rst at round 5 -> outputs clear asynchronously (before the next edge). After release, in_ready=1 and a fresh C.1 job decrypts correctly.
